// File: rtl/keypad_scanner_if.sv
// Key event bus from the keypad scanner to the hex-digit shift register and display path.
// The scanner drives it through the master modport. Consumers read it through the slave modport.
interface keypad_scanner_if;
  logic [3:0] value;
  logic       trig;
  logic       key_down;

  modport master (output value, output trig, output key_down);
  modport slave  (input  value, input  trig, input  key_down);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates the column drive, debounces presses and releases,
// and decodes one key into a hex value. Optional auto-repeat is enabled with KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int REPEAT_TICKS   = 300
) (
  input  logic             clk50M,
  input  logic             rst,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  keypad_scanner_if.master kp
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_DONE  = DB_W'(DEBOUNCE_TICKS);
  // Indexed by {row index, column index}.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  if (SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
    $error("keypad_scanner: needs SCAN_DIV >= 2, DEBOUNCE_TICKS >= 1, REPEAT_TICKS >= 1");
  end

  function automatic logic [1:0] low_idx(input logic [3:0] p);
    case (p)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      default: low_idx = 2'd3;
    endcase
  endfunction

  state_t           state_reg;
  logic [3:0]       row_meta_reg;
  logic [3:0]       srow_reg;
  logic [3:0]       col_reg;
  logic [3:0]       pat_reg;
  logic [3:0]       value_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DB_W-1:0]  db_reg;
  logic [DB_W-1:0]  rc_reg;
  logic             trig_reg;
  logic             key_down_reg;

  logic             tick;
  logic             single_low;
  logic             srow_idle;
  logic [3:0]       col_rot;
  logic [3:0]       key_code;
  logic [DB_W-1:0]  db_inc;
  logic [DB_W-1:0]  rc_inc;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [RPT_W-1:0] RPT_DONE = RPT_W'(REPEAT_TICKS);
  logic [RPT_W-1:0] rpt_reg;
  logic [RPT_W-1:0] rpt_inc;
  assign rpt_inc = rpt_reg + RPT_W'(1);
`endif

  assign tick      = (div_reg == DIV_LAST);
  assign srow_idle = (srow_reg == 4'hF);
  assign col_rot   = {col_reg[2:0], col_reg[3]};
  assign key_code  = KEY_MAP[{low_idx(srow_reg), low_idx(col_reg)}];
  assign db_inc    = db_reg + DB_W'(1);
  assign rc_inc    = rc_reg + DB_W'(1);

  // Ghosting guard: only a single low row is a candidate press.
  always_comb begin
    single_low = 1'b0;
    case (srow_reg)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      row_meta_reg <= 4'hF;
      srow_reg     <= 4'hF;
      div_reg      <= '0;
      state_reg    <= SCAN;
      col_reg      <= 4'b1110;
      pat_reg      <= 4'hF;
      db_reg       <= '0;
      rc_reg       <= '0;
      value_reg    <= 4'h0;
      trig_reg     <= 1'b0;
      key_down_reg <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_reg      <= '0;
`endif
    end else begin
      row_meta_reg <= row;
      srow_reg     <= row_meta_reg;
      div_reg      <= tick ? '0 : div_reg + DIV_W'(1);
      trig_reg     <= 1'b0;
      if (tick) begin
        case (state_reg)
          SCAN: begin
            if (single_low) begin
              pat_reg <= srow_reg;
              db_reg  <= DB_W'(1);
              if (DEBOUNCE_TICKS == 1) begin
                state_reg    <= PRESSED;
                value_reg    <= key_code;
                trig_reg     <= 1'b1;
                key_down_reg <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rpt_reg      <= '0;
`endif
              end else begin
                state_reg <= DEBOUNCE;
              end
            end else begin
              col_reg <= col_rot;
            end
          end
          DEBOUNCE: begin
            if (srow_reg == pat_reg) begin
              db_reg <= db_inc;
              if (db_inc == DB_DONE) begin
                state_reg    <= PRESSED;
                value_reg    <= key_code;
                trig_reg     <= 1'b1;
                key_down_reg <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rpt_reg      <= '0;
`endif
              end
            end else begin
              state_reg <= SCAN;
              col_reg   <= col_rot;
            end
          end
          PRESSED: begin
            if (srow_idle) begin
              rc_reg <= DB_W'(1);
              if (DEBOUNCE_TICKS == 1) begin
                key_down_reg <= 1'b0;
                state_reg    <= SCAN;
                col_reg      <= col_rot;
              end else begin
                state_reg <= RELEASE;
              end
            end
`ifdef KEYPAD_REPEAT_EN
            else if (rpt_inc == RPT_DONE) begin
              trig_reg <= 1'b1;
              rpt_reg  <= '0;
            end else begin
              rpt_reg <= rpt_inc;
            end
`endif
          end
          RELEASE: begin
            if (srow_idle) begin
              rc_reg <= rc_inc;
              if (rc_inc == DB_DONE) begin
                key_down_reg <= 1'b0;
                state_reg    <= SCAN;
                col_reg      <= col_rot;
              end
            end else begin
              // Bounce during release: the key is still held, no new press event.
              state_reg <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
              rpt_reg   <= '0;
`endif
            end
          end
          default: state_reg <= SCAN;
        endcase
      end
    end
  end

  assign col         = col_reg;
  assign kp.value    = value_reg;
  assign kp.trig     = trig_reg;
  assign kp.key_down = key_down_reg;

endmodule
